// File: rtl/sample_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module : sample_feeder_pkg
// Purpose: Shared perceptron package. Holds the feeder state encoding and
//          the default sample width used by the training datapath.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package sample_feeder_pkg;

    // Default signed width of x1/x2/t samples
    localparam int DW_DEFAULT = 8;

    // Feeder sequencing states
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } feeder_state_t;

endpackage : sample_feeder_pkg
`default_nettype wire

// File: rtl/sample_ram.sv
`default_nettype none
// ============================================================================
// Module : sample_ram
// Purpose: DEPTH x WIDTH sample buffer with one write port and one registered
//          read port. Storage is not reset; only the read register is.
// Ports  : clk, rst (async active-low, read register only)
//          we/waddr/wdata  - write port
//          re/raddr/rdata  - registered read port (rdata updates when re=1)
// Rev    : 1.0 - initial release
// ============================================================================
module sample_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [3*DW-1:0]   wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [3*DW-1:0]   rdata
);

    logic [3*DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the feeder's output register, so it is the
    // only part of the buffer that sees reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : sample_ram
`default_nettype wire

// File: rtl/sample_feeder.sv
`default_nettype none
// ============================================================================
// Module : sample_feeder
// Purpose: Buffers training samples (x1, x2, t) and replays them to the
//          perceptron datapath one pass (epoch) at a time under control of
//          the training controller, halting after MAX_EPOCH passes.
// Ports  : clk, rst (async active-low)
//          wr_en, wr_x1, wr_x2, wr_t  - sample fill interface
//          load_done, clear           - end of fill / drop contents
//          ldcnt, cnt_en              - start pass / sample consumed
//          x1, x2, t                  - current sample (registered)
//          cout, full, overflow, count, epoch, armed, halted - status
// Rev    : 1.0 - initial release
// ============================================================================
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter  int DW        = DW_DEFAULT,
    parameter  int DEPTH     = 16,
    parameter  int MAX_EPOCH = 15,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic signed [DW-1:0] wr_x1,
    input  logic signed [DW-1:0] wr_x2,
    input  logic signed [DW-1:0] wr_t,
    input  logic                 load_done,
    input  logic                 clear,
    input  logic                 ldcnt,
    input  logic                 cnt_en,
    output logic signed [DW-1:0] x1,
    output logic signed [DW-1:0] x2,
    output logic signed [DW-1:0] t,
    output logic                 cout,
    output logic                 full,
    output logic                 overflow,
    output logic [AW:0]          count,
    output logic [3:0]           epoch,
    output logic                 armed,
    output logic                 halted
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [4:0]  MAX_EP_C = 5'(MAX_EPOCH);

    feeder_state_t   state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     consumed;
    logic [3*DW-1:0] rdata;
    logic            ram_we;
    logic            ram_re;
    logic [4:0]      epoch_inc;

    assign ram_we    = (state == ST_FILL) && wr_en && !full && !clear;
    // Reading only while running keeps the outputs frozen in every other state
    assign ram_re    = (state == ST_RUN);
    assign epoch_inc = {1'b0, epoch} + 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            consumed <= '0;
            count    <= '0;
            epoch    <= '0;
            cout     <= 1'b0;
            full     <= 1'b0;
            overflow <= 1'b0;
            armed    <= 1'b0;
            halted   <= 1'b0;
        end else if (clear) begin
            state    <= ST_FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            consumed <= '0;
            count    <= '0;
            epoch    <= '0;
            cout     <= 1'b0;
            full     <= 1'b0;
            overflow <= 1'b0;
            armed    <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (wr_en) begin
                        if (!full) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count  <= count + 1'b1;
                            full   <= ((count + 1'b1) == DEPTH_C);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    if (load_done && (count != '0)) begin
                        state <= ST_ARMED;
                        armed <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (ldcnt) begin
                        state    <= ST_RUN;
                        armed    <= 1'b0;
                        rd_ptr   <= '0;
                        consumed <= '0;
                        cout     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // ldcnt outranks a coincident cnt_en
                    if (ldcnt) begin
                        if (epoch_inc == MAX_EP_C) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                            cout   <= 1'b1;
                        end else begin
                            epoch    <= epoch_inc[3:0];
                            consumed <= '0;
                            rd_ptr   <= '0;
                            cout     <= 1'b0;
                        end
                    end else if (cnt_en && !cout) begin
                        consumed <= consumed + 1'b1;
                        rd_ptr   <= ({1'b0, rd_ptr} == (count - 1'b1)) ? '0 : rd_ptr + 1'b1;
                        cout     <= ((consumed + 1'b1) == count);
                    end
                end
                ST_HALT: begin
                    cout <= 1'b1;
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

    sample_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata ({wr_x1, wr_x2, wr_t}),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign x1 = rdata[3*DW-1 -: DW];
    assign x2 = rdata[2*DW-1 -: DW];
    assign t  = rdata[DW-1   -: DW];

endmodule : sample_feeder
`default_nettype wire

// File: tb/tb_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_sample_feeder
// Purpose: Self-checking bench for sample_feeder (DEPTH=16, MAX_EPOCH=2).
//          Written samples are mirrored in a model buffer; every read-advancing
//          stimulus pushes the expected sample to a queue that is popped when
//          the registered output is due.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sample_feeder;

    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int MAX_EPOCH = 2;
    localparam int AW        = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en, load_done, clear, ldcnt, cnt_en;
    logic signed [DW-1:0] wr_x1, wr_x2, wr_t;
    logic signed [DW-1:0] x1, x2, t;
    logic                 cout, full, overflow, armed, halted;
    logic [AW:0]          count;
    logic [3:0]           epoch;

    always #5 clk = ~clk;

    sample_feeder #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .MAX_EPOCH (MAX_EPOCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_x1     (wr_x1),
        .wr_x2     (wr_x2),
        .wr_t      (wr_t),
        .load_done (load_done),
        .clear     (clear),
        .ldcnt     (ldcnt),
        .cnt_en    (cnt_en),
        .x1        (x1),
        .x2        (x2),
        .t         (t),
        .cout      (cout),
        .full      (full),
        .overflow  (overflow),
        .count     (count),
        .epoch     (epoch),
        .armed     (armed),
        .halted    (halted)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] mdl[$];
    logic [23:0] exp_q[$];
    int          m_cons  = 0;
    int          m_epoch = 0;
    bit          m_run   = 0;
    bit          m_halt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mdl.delete();
        exp_q.delete();
        m_cons  = 0;
        m_epoch = 0;
        m_run   = 0;
        m_halt  = 0;
    endtask

    task automatic check_out(input string tag);
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'({x1, x2, t}), 32'(e));
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        wr_en = 1'b1; wr_x1 = a; wr_x2 = b; wr_t = c;
        step();
        wr_en = 1'b0;
        if (mdl.size() < DEPTH) mdl.push_back({a, b, c});
    endtask

    task automatic do_load_done();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
    endtask

    // One consumed-sample pulse, then wait for the registered output
    task automatic do_cnt(input string tag);
        cnt_en = 1'b1;
        step();
        cnt_en = 1'b0;
        if (m_cons < mdl.size()) m_cons++;
        exp_q.push_back(mdl[m_cons % mdl.size()]);
        step();
        check_out(tag);
        check({tag, "_cout"}, 32'(cout), 32'(m_cons == mdl.size()));
    endtask

    task automatic do_ldcnt(input string tag, input bit with_cnt);
        ldcnt  = 1'b1;
        cnt_en = with_cnt;
        step();
        ldcnt  = 1'b0;
        cnt_en = 1'b0;
        if (!m_run) begin
            m_run  = 1;
            m_cons = 0;
        end else if (m_epoch + 1 == MAX_EPOCH) begin
            m_halt = 1;
        end else begin
            m_epoch++;
            m_cons = 0;
        end
        exp_q.push_back(mdl[m_cons % mdl.size()]);
        step();
        check_out(tag);
        check({tag, "_epoch"},  32'(epoch),  32'(m_epoch));
        check({tag, "_halted"}, 32'(halted), 32'(m_halt));
        check({tag, "_cout"},   32'(cout),   32'(m_halt || (m_cons == mdl.size())));
        check({tag, "_armed"},  32'(armed),  32'd0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; load_done = 1'b0; clear = 1'b0;
        ldcnt = 1'b0; cnt_en = 1'b0; wr_x1 = '0; wr_x2 = '0; wr_t = '0;
        step(); step();
        check("rst_outs",  32'({x1, x2, t}), 32'd0);
        check("rst_stat",  32'({cout, full, overflow, armed, halted}), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst = 1'b1;
        step();

        // Basic three-sample pass
        wr(8'd1, 8'd2, 8'd1);
        wr(8'hFF, 8'd3, 8'hFF);
        wr(8'd4, 8'hFE, 8'd1);
        check("fill_count", 32'(count), 32'd3);
        do_load_done();
        check("armed_set", 32'(armed), 32'd1);
        do_ldcnt("first_pass", 1'b0);
        do_cnt("mid_cnt");
        // ldcnt beats cnt_en mid-pass
        do_ldcnt("ld_cnt_same", 1'b1);
        for (int k = 0; k < 3; k++) do_cnt($sformatf("pass_cnt%0d", k));
        do_cnt("cnt_saturate");
        // epoch 1 + 1 == MAX_EPOCH -> halt
        do_ldcnt("halt", 1'b0);
        cnt_en = 1'b1; wr_en = 1'b1; wr_x1 = 8'h55;
        step(); step();
        cnt_en = 1'b0; wr_en = 1'b0;
        exp_q.push_back(mdl[0]);
        check_out("halt_frozen");
        check("halt_ovf",   32'(overflow), 32'd0);
        check("halt_count", 32'(count), 32'd3);

        // Clear, then reset in the middle of a pass
        do_clear();
        check("clr_stat", 32'({halted, cout, armed, overflow, full}), 32'd0);
        check("clr_cnt",  32'({count, epoch}), 32'd0);
        wr(8'd7, 8'd8, 8'd1);
        wr(8'd9, 8'hF0, 8'hFF);
        do_load_done();
        do_ldcnt("re_pass", 1'b0);
        do_cnt("re_cnt");
        rst = 1'b0;
        #1;
        check("async_outs", 32'({x1, x2, t}), 32'd0);
        check("async_stat", 32'({cout, full, overflow, armed, halted}), 32'd0);
        check("async_cnt",  32'({count, epoch}), 32'd0);
        model_reset();
        step();
        rst = 1'b1;
        step();
        do_load_done();
        step();
        check("empty_load", 32'(armed), 32'd0);

        // Overfill by one
        for (int i = 0; i < DEPTH + 1; i++)
            wr(8'(i + 1), 8'(-(i + 1)), (i % 2 == 0) ? 8'd1 : 8'hFF);
        check("ovf_count", 32'(count), 32'(DEPTH));
        check("ovf_full",  32'(full), 32'd1);
        check("ovf_flag",  32'(overflow), 32'd1);
        do_load_done();
        do_ldcnt("ovf_pass", 1'b0);
        for (int k = 0; k < DEPTH; k++) do_cnt($sformatf("ovf_rd%0d", k));
        do_clear();
        check("ovf_clear", 32'({overflow, full, count}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sample_feeder
`default_nettype wire
